rf_wb_arbiter: RTL and testbench

- Owns the single register-file write port (we/wa/wd). Arbitrates it between two writeback requesters:
  - the in-order pipeline writeback stage (port P);
  - the multi-cycle mul/div unit (port M).
- Holds a pending-write scoreboard for M destinations. This gives M issue flow control and a read-after-write hazard flag to decode.
- Sits between the WB stage / MDU and the register file. Output is registered, so each write reaches the register file one cycle after acceptance.

---
 rtl/rf_wb_arbiter_pkg.sv | 18 +
 rtl/rf_scoreboard.sv | 65 ++++++
 rtl/rf_wb_arbiter.sv | 91 +++++++++
 tb/tb_rf_wb_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared defaults and helpers for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

   localparam int AW_DEF         = 5;
   localparam int DW_DEF         = 32;
   localparam int STARVE_MAX_DEF = 4;
   localparam int MAX_OUT_DEF    = 2;

   localparam logic [4:0] REG_ZERO = 5'd0;

   function automatic logic reg_busy(
      input logic [31:0] b,
      input logic [4:0]  r
   );
      return (r != REG_ZERO) && b[r];
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for MDU destinations: busy bits,
// outstanding count, issue flow control and decode hazard.
module rf_scoreboard
   import rf_wb_arbiter_pkg::*;
#(
   parameter int MAX_OUT = MAX_OUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iss_valid,
   input  logic [4:0]  iss_wa,
   output logic        iss_ready,
   input  logic        m_acc,
   input  logic [4:0]  m_wa,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic        hazard,
   output logic [31:0] busy_mask
);

   localparam int OCW = $clog2(MAX_OUT + 1);

   logic [31:0]    busy;
   logic [31:0]    busy_nxt;
   logic [OCW-1:0] out_cnt;
   logic [OCW-1:0] out_nxt;
   logic           iss_acc;

   // A pending destination blocks re-issue to avoid WAW reordering.
   assign iss_ready = (out_cnt < OCW'(MAX_OUT))
                   && ((iss_wa == REG_ZERO) || !busy[iss_wa]);
   assign iss_acc   = iss_valid && iss_ready;

   assign hazard    = reg_busy(busy, rs1) || reg_busy(busy, rs2);
   assign busy_mask = busy;

   always_comb begin
      busy_nxt = busy;
      if (m_acc)
         busy_nxt[m_wa] = 1'b0;
      if (iss_acc && (iss_wa != REG_ZERO))
         busy_nxt[iss_wa] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_comb begin
      out_nxt = out_cnt;
      unique case ({iss_acc, m_acc})
         2'b10:   out_nxt = out_cnt + OCW'(1);
         2'b01:   if (out_cnt != '0) out_nxt = out_cnt - OCW'(1);
         default: out_nxt = out_cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy    <= '0;
         out_cnt <= '0;
      end else begin
         busy    <= busy_nxt;
         out_cnt <= out_nxt;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-file write port between the pipeline WB
// stage and the MDU, with starvation guard and registered output.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF,
   parameter int MAX_OUT    = MAX_OUT_DEF,
   parameter int DW         = DW_DEF,
   parameter int AW         = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p_valid,
   output logic          p_ready,
   input  logic [AW-1:0] p_wa,
   input  logic [DW-1:0] p_wd,
   input  logic          m_valid,
   output logic          m_ready,
   input  logic [AW-1:0] m_wa,
   input  logic [DW-1:0] m_wd,
   input  logic          iss_valid,
   input  logic [AW-1:0] iss_wa,
   output logic          iss_ready,
   input  logic [AW-1:0] rs1,
   input  logic [AW-1:0] rs2,
   output logic          hazard,
   output logic [31:0]   busy_mask,
   output logic          rf_we,
   output logic [AW-1:0] rf_wa,
   output logic [DW-1:0] rf_wd
);

   localparam int SCW = $clog2(STARVE_MAX + 1);

   logic [SCW-1:0] starve_cnt;
   logic           force_m;
   logic           p_acc;
   logic           m_acc;

   assign force_m = m_valid && (starve_cnt == SCW'(STARVE_MAX));
   assign p_ready = !force_m;
   assign m_ready = force_m || !p_valid;
   assign p_acc   = p_valid && p_ready;
   assign m_acc   = m_valid && m_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (!m_valid || m_acc) begin
         starve_cnt <= '0;
      end else if (p_acc) begin
         starve_cnt <= starve_cnt + SCW'(1);
      end
   end

   // x0 writes are consumed but never pulse rf_we.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rf_we <= 1'b0;
         rf_wa <= '0;
         rf_wd <= '0;
      end else if (p_acc) begin
         rf_we <= (p_wa != '0);
         rf_wa <= p_wa;
         rf_wd <= p_wd;
      end else if (m_acc) begin
         rf_we <= (m_wa != '0);
         rf_wa <= m_wa;
         rf_wd <= m_wd;
      end else begin
         rf_we <= 1'b0;
      end
   end

   rf_scoreboard #(
      .MAX_OUT (MAX_OUT)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (iss_valid),
      .iss_wa    (iss_wa),
      .iss_ready (iss_ready),
      .m_acc     (m_acc),
      .m_wa      (m_wa),
      .rs1       (rs1),
      .rs2       (rs2),
      .hazard    (hazard),
      .busy_mask (busy_mask)
   );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with hand-computed expectations.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        p_valid, p_ready;
   logic [4:0]  p_wa;
   logic [31:0] p_wd;
   logic        m_valid, m_ready;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   logic        iss_valid, iss_ready;
   logic [4:0]  iss_wa;
   logic [4:0]  rs1, rs2;
   logic        hazard;
   logic [31:0] busy_mask;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rf_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .p_valid   (p_valid),
      .p_ready   (p_ready),
      .p_wa      (p_wa),
      .p_wd      (p_wd),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_wa      (m_wa),
      .m_wd      (m_wd),
      .iss_valid (iss_valid),
      .iss_wa    (iss_wa),
      .iss_ready (iss_ready),
      .rs1       (rs1),
      .rs2       (rs2),
      .hazard    (hazard),
      .busy_mask (busy_mask),
      .rf_we     (rf_we),
      .rf_wa     (rf_wa),
      .rf_wd     (rf_wd)
   );

   task automatic check(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      p_valid   = 1'b0;
      p_wa      = '0;
      p_wd      = '0;
      m_valid   = 1'b0;
      m_wa      = '0;
      m_wd      = '0;
      iss_valid = 1'b0;
      iss_wa    = '0;
      rs1       = '0;
      rs2       = '0;
   endtask

   initial begin
      // 1: reset with every input active
      rst       = 1'b0;
      p_valid   = 1'b1;
      p_wa      = 5'd3;
      p_wd      = 32'h1111;
      m_valid   = 1'b1;
      m_wa      = 5'd4;
      m_wd      = 32'h2222;
      iss_valid = 1'b1;
      iss_wa    = 5'd7;
      rs1       = 5'd7;
      rs2       = 5'd7;
      step();
      step();
      check("rst_we",   rf_we, 0);
      check("rst_wa",   rf_wa, 0);
      check("rst_wd",   rf_wd, 0);
      check("rst_busy", busy_mask, 0);
      idle();
      rs1 = 5'd7;
      rst = 1'b1;
      #1;
      check("rst_iss_rdy", iss_ready, 1);
      check("rst_hazard",  hazard, 0);

      // 2: P only
      p_valid = 1'b1;
      p_wa    = 5'd3;
      p_wd    = 32'hDEADBEEF;
      #1;
      check("p_ready", p_ready, 1);
      step();
      p_valid = 1'b0;
      check("p_we", rf_we, 1);
      check("p_wa", rf_wa, 3);
      check("p_wd", rf_wd, 32'hDEADBEEF);
      step();
      check("p_we_pulse", rf_we, 0);
      check("p_wa_hold",  rf_wa, 3);

      // 3: starvation, with a real outstanding M op to x9
      iss_valid = 1'b1;
      iss_wa    = 5'd9;
      #1;
      check("st_iss_rdy", iss_ready, 1);
      step();
      iss_valid = 1'b0;
      check("st_busy9", busy_mask, 32'h200);
      p_valid = 1'b1;
      p_wa    = 5'd1;
      m_valid = 1'b1;
      m_wa    = 5'd9;
      m_wd    = 32'hAA;
      for (int k = 1; k <= 4; k++) begin
         p_wd = 32'(k);
         #1;
         check("st_p_rdy", p_ready, 1);
         check("st_m_rdy", m_ready, 0);
         step();
         check("st_p_wd", rf_wd, 64'(k));
      end
      #1;
      check("st_force_p", p_ready, 0);
      check("st_force_m", m_ready, 1);
      step();
      check("st_m_wa",  rf_wa, 9);
      check("st_m_wd",  rf_wd, 32'hAA);
      check("st_m_we",  rf_we, 1);
      check("st_clr9",  busy_mask, 0);
      p_wd = 32'h66;
      #1;
      check("st_p_again", p_ready, 1);
      check("st_m_wait",  m_ready, 0);
      m_valid = 1'b0;
      step();
      p_valid = 1'b0;
      check("st_p6_wd", rf_wd, 32'h66);

      // 4: scoreboard set / WAW block / clear
      iss_valid = 1'b1;
      iss_wa    = 5'd7;
      step();
      iss_valid = 1'b0;
      rs1 = 5'd7;
      #1;
      check("sb_busy7", busy_mask, 32'h80);
      check("sb_haz_rs1", hazard, 1);
      rs1 = 5'd0;
      rs2 = 5'd7;
      #1;
      check("sb_haz_rs2", hazard, 1);
      iss_valid = 1'b1;
      #1;
      check("sb_waw", iss_ready, 0);
      iss_valid = 1'b0;
      m_valid = 1'b1;
      m_wa    = 5'd7;
      m_wd    = 32'h77;
      #1;
      check("sb_m_rdy", m_ready, 1);
      step();
      m_valid = 1'b0;
      check("sb_clr7",  busy_mask, 0);
      check("sb_haz0",  hazard, 0);
      check("sb_m_wa",  rf_wa, 7);
      rs2 = 5'd0;

      // 5: outstanding limit
      iss_valid = 1'b1;
      iss_wa    = 5'd5;
      step();
      iss_wa    = 5'd6;
      step();
      iss_wa    = 5'd8;
      #1;
      check("ol_full", iss_ready, 0);
      m_valid = 1'b1;
      m_wa    = 5'd5;
      #1;
      check("ol_same_cyc", iss_ready, 0);
      step();
      m_valid = 1'b0;
      check("ol_next_rdy", iss_ready, 1);
      step();
      iss_valid = 1'b0;
      check("ol_busy", busy_mask, 32'h140);
      m_valid = 1'b1;
      m_wa    = 5'd6;
      step();
      m_wa    = 5'd8;
      step();
      m_valid = 1'b0;
      check("ol_drain", busy_mask, 0);

      // 6: x0 handling
      p_valid = 1'b1;
      p_wa    = 5'd0;
      p_wd    = 32'h123;
      #1;
      check("x0_p_rdy", p_ready, 1);
      step();
      p_valid = 1'b0;
      check("x0_we", rf_we, 0);
      check("x0_wa", rf_wa, 0);
      iss_valid = 1'b1;
      iss_wa    = 5'd0;
      #1;
      check("x0_iss1", iss_ready, 1);
      step();
      check("x0_iss2", iss_ready, 1);
      step();
      iss_valid = 1'b0;
      #1;
      check("x0_cnt_full", iss_ready, 0);
      check("x0_busy",     busy_mask, 0);
      check("x0_haz",      hazard, 0);
      m_valid = 1'b1;
      m_wa    = 5'd0;
      step();
      step();
      m_valid = 1'b0;
      check("x0_m_we", rf_we, 0);
      check("x0_cnt_drain", iss_ready, 1);

      // reset mid-operation discards pending entries
      iss_valid = 1'b1;
      iss_wa    = 5'd4;
      step();
      iss_valid = 1'b0;
      check("mr_busy4", busy_mask, 32'h10);
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("mr_clr", busy_mask, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
